// File: rtl/range_parser.sv
// range_parser
//   Parses an ASCII stream of "lo-hi" decimal ranges separated by ',' or LF
//   (for example "11-22,95-115\n") and emits one {lo, hi, lo-1} tuple per range.
//   This block feeds count_combs: the sequencer drives it with hi and lo-1.
//
// Byte handshake:  a byte is accepted on a rising clock edge where
//                  byte_valid && byte_ready. Tuples are accepted on a rising
//                  edge where range_valid && range_ready. range_valid and the
//                  tuple stay stable until they are accepted, and byte_ready
//                  is low while a tuple is waiting.
//
// Ports:
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   byte_in      ASCII character
//   byte_valid   byte_in is valid
//   byte_last    byte_in is the final byte of the stream (EOF)
//   byte_ready   byte accepted when byte_valid && byte_ready
//   range_lo     parsed lower bound
//   range_hi     parsed upper bound
//   range_lo_m1  range_lo - 1, saturating at 0
//   range_valid  tuple valid, held until range_ready
//   range_ready  downstream accepts the tuple
//   range_count  number of tuples accepted downstream (wraps)
//   err          sticky parse error
//   done         stream finished (clean or error)
//   fsm_state    current parser state (debug observation)
//
// Optional feature macro: RANGE_ORDER_CHECK_EN
//   When defined, a range with lo > hi is an error instead of a tuple.

module range_parser #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic [DATA_WIDTH-1:0] range_lo,
    output logic [DATA_WIDTH-1:0] range_hi,
    output logic [DATA_WIDTH-1:0] range_lo_m1,
    output logic                  range_valid,
    input  logic                  range_ready,
    output logic [CNT_WIDTH-1:0]  range_count,
    output logic                  err,
    output logic                  done,
    output logic [2:0]            fsm_state
);

    typedef enum logic [2:0] {
        S_LO   = 3'd0,
        S_HI   = 3'd1,
        S_EMIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam int PW = DATA_WIDTH + 4;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] acc_lo, acc_lo_n;
    logic [DATA_WIDTH-1:0] acc_hi, acc_hi_n;
    logic                  have_lo, have_lo_n;
    logic                  have_hi, have_hi_n;
    logic                  last_pending, last_pending_n;
    logic [DATA_WIDTH-1:0] lo_m1;
    logic [CNT_WIDTH-1:0]  count;

    logic                  accept;
    logic                  is_digit;
    logic                  is_sep;
    logic                  is_blank;
    logic [DATA_WIDTH-1:0] field;
    logic [PW-1:0]         prod;
    logic                  ovf;

    assign accept   = byte_valid && byte_ready;
    assign is_digit = (byte_in >= 8'h30) && (byte_in <= 8'h39);
    assign is_sep   = (byte_in == 8'h2C) || (byte_in == 8'h0A);
    assign is_blank = (byte_in == 8'h0D) || (byte_in == 8'h20);

    // The field being typed; the multiply-accumulate is evaluated four bits
    // wider so any carry out of DATA_WIDTH marks an overflow. For ASCII
    // digits the low nibble is the digit value.
    assign field = (state == S_HI) ? acc_hi : acc_lo;
    assign prod  = {4'b0000, field} * PW'(10) + PW'(byte_in[3:0]);
    assign ovf   = |prod[PW-1:DATA_WIDTH];

    always_comb begin
        state_n        = state;
        acc_lo_n       = acc_lo;
        acc_hi_n       = acc_hi;
        have_lo_n      = have_lo;
        have_hi_n      = have_hi;
        last_pending_n = last_pending;

        case (state)
            S_LO, S_HI: begin
                if (accept) begin
                    if (is_digit) begin
                        if (ovf) begin
                            state_n = S_ERR;
                        end else if (state == S_LO) begin
                            acc_lo_n  = prod[DATA_WIDTH-1:0];
                            have_lo_n = 1'b1;
                        end else begin
                            acc_hi_n  = prod[DATA_WIDTH-1:0];
                            have_hi_n = 1'b1;
                        end
                    end else if (is_blank) begin
                        state_n = state;
                    end else if (byte_in == 8'h2D) begin
                        state_n = (state == S_LO && have_lo) ? S_HI : S_ERR;
                    end else if (is_sep) begin
                        if (state == S_HI)
                            state_n = have_hi ? S_EMIT : S_ERR;
                        else if (have_lo)
                            state_n = S_ERR;
                    end else begin
                        state_n = S_ERR;
                    end

                    // EOF is resolved against the state after this byte.
                    if (byte_last && state_n != S_ERR) begin
                        if (state_n == S_EMIT || (state_n == S_HI && have_hi_n)) begin
                            state_n        = S_EMIT;
                            last_pending_n = 1'b1;
                        end else if (state_n == S_LO && !have_lo_n) begin
                            state_n = S_DONE;
                        end else begin
                            state_n = S_ERR;
                        end
                    end

`ifdef RANGE_ORDER_CHECK_EN
                    if (state_n == S_EMIT && acc_lo_n > acc_hi_n)
                        state_n = S_ERR;
`endif
                end
            end
            S_EMIT: begin
                if (range_ready) begin
                    state_n        = last_pending ? S_DONE : S_LO;
                    acc_lo_n       = '0;
                    acc_hi_n       = '0;
                    have_lo_n      = 1'b0;
                    have_hi_n      = 1'b0;
                    last_pending_n = 1'b0;
                end
            end
            default: begin
                state_n = state;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_LO;
            acc_lo       <= '0;
            acc_hi       <= '0;
            have_lo      <= 1'b0;
            have_hi      <= 1'b0;
            last_pending <= 1'b0;
            lo_m1        <= '0;
            count        <= '0;
        end else begin
            state        <= state_n;
            acc_lo       <= acc_lo_n;
            acc_hi       <= acc_hi_n;
            have_lo      <= have_lo_n;
            have_hi      <= have_hi_n;
            last_pending <= last_pending_n;
            if (state != S_EMIT && state_n == S_EMIT)
                lo_m1 <= (acc_lo_n == '0) ? '0 : acc_lo_n - DATA_WIDTH'(1);
            if (state == S_EMIT && range_ready)
                count <= count + CNT_WIDTH'(1);
        end
    end

    // The accumulators do not change while in EMIT, so they serve directly
    // as the held tuple.
    assign range_lo    = acc_lo;
    assign range_hi    = acc_hi;
    assign range_lo_m1 = lo_m1;
    assign range_valid = (state == S_EMIT);
    assign byte_ready  = (state != S_EMIT);
    assign range_count = count;
    assign err         = (state == S_ERR);
    assign done        = (state == S_DONE) || (state == S_ERR);
    assign fsm_state   = state;

endmodule

// File: tb/tb_range_parser.sv
module tb_range_parser;

    localparam logic [63:0] MAXV = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clock;
    logic        reset_n;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_last;
    logic        byte_ready;
    logic [63:0] range_lo;
    logic [63:0] range_hi;
    logic [63:0] range_lo_m1;
    logic        range_valid;
    logic        range_ready;
    logic [15:0] range_count;
    logic        err;
    logic        done;
    logic [2:0]  fsm_state;

    int total = 0;
    int bad   = 0;

    logic [191:0] exp_q[$];

    range_parser #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_last   (byte_last),
        .byte_ready  (byte_ready),
        .range_lo    (range_lo),
        .range_hi    (range_hi),
        .range_lo_m1 (range_lo_m1),
        .range_valid (range_valid),
        .range_ready (range_ready),
        .range_count (range_count),
        .err         (err),
        .done        (done),
        .fsm_state   (fsm_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic do_reset();
        byte_valid  = 1'b0;
        byte_in     = 8'h00;
        byte_last   = 1'b0;
        range_ready = 1'b1;
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives bytes in order, holding each until accepted; no tuple handling.
    task automatic feed(input string s, input bit use_last);
        int guard;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clock);
            byte_valid = 1'b1;
            byte_in    = s[i];
            byte_last  = use_last && (i == s.len() - 1);
            guard = 0;
            while (!byte_ready && guard < 100) begin
                @(negedge clock);
                guard++;
            end
            if (guard >= 100) chk("feed_timeout", 64'd1, 64'd0);
        end
        @(negedge clock);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    // Drives the stream while acting as the tuple sink; the first tuple is
    // stalled for 'stall' cycles and checked for stability meanwhile.
    task automatic run_stream(input string s, input int stall, input bit use_last);
        int idx = 0;
        int cyc = 0;
        int left = stall;
        bit pend = 1'b1;
        logic [191:0] t;
        while ((idx < s.len() || range_valid || pend) && cyc < 2000) begin
            @(negedge clock);
            cyc++;
            pend = 1'b0;
            if (range_valid) begin
                if (left > 0) begin
                    range_ready = 1'b0;
                    left--;
                    if (exp_q.size() > 0) begin
                        t = exp_q[0];
                        chk("stall_lo", range_lo, t[191:128]);
                        chk("stall_hi", range_hi, t[127:64]);
                        chk("stall_lo_m1", range_lo_m1, t[63:0]);
                    end
                    chk("stall_byte_ready", 64'(byte_ready), 64'd0);
                end else begin
                    range_ready = 1'b1;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_tuple: got (%0d,%0d,%0d) expected none",
                                 range_lo, range_hi, range_lo_m1);
                    end else begin
                        t = exp_q.pop_front();
                        chk("tuple_lo", range_lo, t[191:128]);
                        chk("tuple_hi", range_hi, t[127:64]);
                        chk("tuple_lo_m1", range_lo_m1, t[63:0]);
                    end
                end
            end else begin
                range_ready = 1'b1;
            end
            if (idx < s.len()) begin
                byte_valid = 1'b1;
                byte_in    = s[idx];
                byte_last  = use_last && (idx == s.len() - 1);
                if (byte_ready) begin
                    idx++;
                    pend = 1'b1;
                end
            end else begin
                byte_valid = 1'b0;
                byte_last  = 1'b0;
            end
        end
        if (cyc >= 2000) chk("stream_timeout", 64'd1, 64'd0);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    typedef struct {
        string       s;
        int          stall;
        int          n;
        logic [63:0] lo0, hi0, m10;
        logic [63:0] lo1, hi1, m11;
        bit          e_err;
        bit          e_done;
        int          e_cnt;
    } vec_t;

    function automatic vec_t mk(input string s, input int stall, input int n,
                                input logic [63:0] lo0, input logic [63:0] hi0, input logic [63:0] m10,
                                input logic [63:0] lo1, input logic [63:0] hi1, input logic [63:0] m11,
                                input bit e_err, input bit e_done, input int e_cnt);
        vec_t v;
        v.s = s; v.stall = stall; v.n = n;
        v.lo0 = lo0; v.hi0 = hi0; v.m10 = m10;
        v.lo1 = lo1; v.hi1 = hi1; v.m11 = m11;
        v.e_err = e_err; v.e_done = e_done; v.e_cnt = e_cnt;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        vecs.push_back(mk("11-22,95-115\n", 0, 2, 11, 22, 10, 95, 115, 94, 0, 1, 2));
        vecs.push_back(mk("0-5", 0, 1, 0, 5, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk("3-7,8-9", 5, 2, 3, 7, 2, 8, 9, 7, 0, 1, 2));
        vecs.push_back(mk("12-x4", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
`ifdef RANGE_ORDER_CHECK_EN
        vecs.push_back(mk("50-10\n", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
`else
        vecs.push_back(mk("50-10\n", 0, 1, 50, 10, 49, 0, 0, 0, 0, 1, 1));
`endif
        vecs.push_back(mk(" 7-8\r\n,\n", 0, 1, 7, 8, 6, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk("5,6-7\n", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk("-3-4\n", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk("1-\n", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk("1-2-3\n", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk("4-5,6", 0, 1, 4, 5, 3, 0, 0, 0, 1, 1, 1));
        vecs.push_back(mk("18446744073709551615-18446744073709551615\n", 0, 1,
                          MAXV, MAXV, MAXV - 64'd1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk("18446744073709551616-1\n", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));

        // reset state
        reset_n     = 1'b1;
        byte_valid  = 1'b0;
        byte_in     = 8'h00;
        byte_last   = 1'b0;
        range_ready = 1'b0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_byte_ready", 64'(byte_ready), 64'd1);
        chk("rst_range_valid", 64'(range_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_count", 64'(range_count), 64'd0);
        chk("rst_lo", range_lo, 64'd0);
        chk("rst_hi", range_hi, 64'd0);
        chk("rst_lo_m1", range_lo_m1, 64'd0);
        reset_n = 1'b1;

        // table-driven streams
        foreach (vecs[k]) begin
            do_reset();
            if (vecs[k].n > 0) exp_q.push_back({vecs[k].lo0, vecs[k].hi0, vecs[k].m10});
            if (vecs[k].n > 1) exp_q.push_back({vecs[k].lo1, vecs[k].hi1, vecs[k].m11});
            run_stream(vecs[k].s, vecs[k].stall, 1'b1);
            repeat (2) @(negedge clock);
            chk({"end_err:", vecs[k].s}, 64'(err), 64'(vecs[k].e_err));
            chk({"end_done:", vecs[k].s}, 64'(done), 64'(vecs[k].e_done));
            chk({"end_count:", vecs[k].s}, 64'(range_count), 64'(vecs[k].e_cnt));
            chk({"missing_tuples:", vecs[k].s}, 64'(exp_q.size()), 64'd0);
            chk({"end_valid:", vecs[k].s}, 64'(range_valid), 64'd0);
            chk({"end_byte_ready:", vecs[k].s}, 64'(byte_ready), 64'd1);
        end

        // error at the offending byte, then draining
        do_reset();
        feed("12-x", 1'b0);
        chk("bad_char_err", 64'(err), 64'd1);
        chk("bad_char_done", 64'(done), 64'd1);
        feed("4,5", 1'b1);
        chk("drain_byte_ready", 64'(byte_ready), 64'd1);
        chk("drain_count", 64'(range_count), 64'd0);

        // overflow on the 20th '9' (19 nines still fit in 64 bits)
        do_reset();
        feed("9999999999999999999", 1'b0);
        chk("ovf_19_err", 64'(err), 64'd0);
        feed("9", 1'b0);
        chk("ovf_20_err", 64'(err), 64'd1);
        feed("9", 1'b1);
        chk("ovf_21_done", 64'(done), 64'd1);

        // reset while a tuple is pending drops range_valid immediately
        do_reset();
        range_ready = 1'b0;
        feed("9-9,", 1'b0);
        chk("pend_valid", 64'(range_valid), 64'd1);
        chk("pend_byte_ready", 64'(byte_ready), 64'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_valid", 64'(range_valid), 64'd0);
        chk("async_lo", range_lo, 64'd0);
        chk("async_byte_ready", 64'(byte_ready), 64'd1);
        @(negedge clock);
        reset_n = 1'b1;
        range_ready = 1'b1;

        // reset mid-parse clears the accumulators
        do_reset();
        feed("123-4", 1'b0);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("mid_rst_state", 64'(fsm_state), 64'd0);
        chk("mid_rst_lo", range_lo, 64'd0);
        chk("mid_rst_hi", range_hi, 64'd0);
        reset_n = 1'b1;
        exp_q.delete();
        exp_q.push_back({64'd1, 64'd2, 64'd0});
        run_stream("1-2\n", 0, 1'b1);
        repeat (2) @(negedge clock);
        chk("post_rst_missing", 64'(exp_q.size()), 64'd0);
        chk("post_rst_count", 64'(range_count), 64'd1);
        chk("post_rst_done", 64'(done), 64'd1);
        chk("post_rst_err", 64'(err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/range_parser.md
Name: range_parser

Overview:
- Upstream feeder for count_combs in the AOC day-2 datapath.
- Consumes the ASCII puzzle stream (e.g. "11-22,95-115\n") one byte per handshake and parses decimal bounds.
- Emits one {lo, hi, lo-1} tuple per range over a valid/ready handshake.
- The sequencer drives count_combs with hi and lo-1 and accumulates the difference.

Parameters:
- DATA_WIDTH, 64, width of each parsed bound; matches the count_combs n_in width.
- CNT_WIDTH, 16, width of the emitted-range counter.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- byte_in  in  8  ASCII character.
- byte_valid  in  1  byte_in is valid.
- byte_last  in  1  qualifies byte_in as the final byte of the stream (EOF).
- byte_ready  out  1  byte accepted when byte_valid && byte_ready.
- range_lo  out  DATA_WIDTH  parsed lower bound.
- range_hi  out  DATA_WIDTH  parsed upper bound.
- range_lo_m1  out  DATA_WIDTH  range_lo-1, saturating at 0.
- range_valid  out  1  tuple valid; held until range_ready.
- range_ready  in  1  downstream accepts tuple.
- range_count  out  CNT_WIDTH  number of tuples accepted downstream.
- err  out  1  sticky parse error.
- done  out  1  stream finished (clean or error).

Behaviour:
- Reset (async, reset_n=0): state=LO, both accumulators and digit flags cleared. All outputs are 0 except byte_ready.
- byte_ready=1 in LO, HI, DONE and ERR. byte_ready=0 in EMIT.
- Digit handling:
  - Digits '0'..'9' in LO or HI: acc <= acc*10 + (byte-"0").
  - acc*10+d computed at DATA_WIDTH+4 bits. If the result exceeds 2^DATA_WIDTH-1, go to ERR.
  - A per-field have_digit flag is set on each digit.
- Separator and whitespace handling:
  - '-' in LO with have_digit: go to HI.
  - '-' in LO without have_digit, or '-' in HI: go to ERR.
  - ',' or LF (10) in HI with have_digit: go to EMIT.
  - ',' or LF in HI without have_digit: go to ERR.
  - ',' or LF in LO without have_digit: ignored (blank line, trailing separator).
  - ',' or LF in LO with have_digit: go to ERR (missing hi).
  - CR (13) and space (32): ignored in every state.
  - Any other byte in LO or HI: go to ERR.
- EOF (byte_last=1 on an accepted byte):
  - The byte is processed first.
  - In HI with have_digit (and no error): go to EMIT with last_pending=1.
  - In LO without have_digit: go to DONE.
  - Otherwise: go to ERR.
- EMIT:
  - range_valid=1 starting the cycle after the terminating byte is accepted (1-cycle latency).
  - range_lo, range_hi and range_lo_m1 are registered and stable while range_valid=1.
  - When range_valid && range_ready: range_count++, accumulators clear, next state is LO, or DONE if last_pending.
  - range_valid deasserts the following cycle.
- Counter: range_count wraps modulo 2^CNT_WIDTH.
- DONE:
  - done=1; bytes are accepted and discarded.
  - Exit only by reset.
- ERR:
  - err=1 and done=1, both sticky; bytes are drained and discarded.
  - range_valid=0; no further tuples.
- range_lo_m1 = (lo==0) ? 0 : lo-1.
- Simultaneous byte_valid with state EMIT: no acceptance (byte_ready=0). The upstream must hold the byte.
- Reset asserted mid-EMIT: range_valid drops immediately (asynchronously). The tuple is lost.

Optional Feature:
- Macro: RANGE_ORDER_CHECK_EN.
- Defined:
  - At the HI-to-EMIT transition, if lo > hi, go to ERR instead of EMIT.
  - No tuple is emitted, err=1.
- Undefined:
  - No ordering check; the tuple is emitted as parsed.
  - The downstream difference is then undefined by this block.

Test Plan:
- Stream "11-22,95-115\n" (last on LF) with range_ready=1 ->
  - Two tuples: (11,22,10) then (95,115,94).
  - range_count=2, done=1, err=0.
- Stream "0-5" (last on '5') with range_ready=1 ->
  - Tuple (0,5,0), saturated lo_m1.
  - done=1 after the handshake.
- Stream "3-7,8-9", range_ready held 0 for 5 cycles after the first tuple ->
  - Tuple (3,7,2) stable all 5 cycles and byte_ready=0.
  - On release the second tuple (8,9,7) follows.
- Stream "12-x4" -> err=1 and done=1 at 'x', no tuple emitted, remaining bytes drained with byte_ready=1.
- Stream of 21 '9' digits (DATA_WIDTH=64) -> err=1 on the overflowing digit.
- With RANGE_ORDER_CHECK_EN, stream "50-10\n" -> err=1, range_count=0.
- Without RANGE_ORDER_CHECK_EN, stream "50-10\n" -> tuple (50,10,49).
- Mid-stream "123-4" then reset_n=0 -> all state cleared.
- After the reset above, stream "1-2\n" -> tuple (1,2,0).
